// File: rtl/usb_data_buffer.sv
// Byte FIFO shared by the AHB-Lite USB slave (host side) and the USB RX/TX
// packet engines. First-word fall-through head, live occupancy, sticky error.
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_rx_data,
  output logic [7:0] rx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output logic [6:0] buffer_occupancy,
  output logic       buffer_error
);

  localparam logic [6:0] FULL_COUNT = 7'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [6:0]        count;

  logic       push;
  logic       pop;
  logic       do_push;
  logic       do_pop;
  logic       err_set;
  logic [7:0] wdata;
  logic [7:0] head;

  assign push    = store_tx_data | store_rx_packet_data;
  assign pop     = get_rx_data | get_tx_packet_data;
  assign do_pop  = pop & (count != 7'd0);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push & ((count != FULL_COUNT) | do_pop);

  // Host byte wins a push collision; the RX engine byte is dropped.
  assign wdata = store_tx_data ? tx_data : rx_packet_data;

  assign err_set = (store_tx_data & store_rx_packet_data)
                 | (get_rx_data & get_tx_packet_data)
                 | (push & ~do_push)
                 | (pop & ~do_pop);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      buffer_error <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      buffer_error <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {6'd0, do_push} - {6'd0, do_pop};
      if (err_set) buffer_error <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the head output is masked to 8'h00
  // while empty, so stale contents are never visible and the array can map
  // onto plain RAM or flops without reset wiring.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign head             = (count != 7'd0) ? mem[rd_ptr] : 8'h00;
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = count;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: stimulus queues expected head bytes and
// state snapshots; a monitor compares them on the falling edge.
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_error;

  typedef struct {
    string      name;
    logic [6:0] occ;
    logic       err;
    logic [7:0] head;
  } state_exp_t;

  state_exp_t state_q [$];
  logic [7:0] byte_q  [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  usb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_error         (buffer_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [6:0] occ,
                              input logic err, input logic [7:0] head);
    state_exp_t e;
    e.name = name;
    e.occ  = occ;
    e.err  = err;
    e.head = head;
    state_q.push_back(e);
  endtask

  task automatic idle_inputs();
    clear                = 1'b0;
    store_tx_data        = 1'b0;
    tx_data              = 8'h00;
    get_rx_data          = 1'b0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    get_tx_packet_data   = 1'b0;
  endtask

  // Monitor: every falling edge, check the head byte of any pop about to be
  // sampled, then every pending state snapshot.
  initial begin
    state_exp_t e;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (n_rst && (get_rx_data || get_tx_packet_data) &&
          buffer_occupancy != 7'd0 && byte_q.size() > 0) begin
        b = byte_q.pop_front();
        check("pop_rx_data", {24'd0, rx_data}, {24'd0, b});
        check("pop_tx_packet_data", {24'd0, tx_packet_data}, {24'd0, b});
      end
      while (state_q.size() > 0) begin
        e = state_q.pop_front();
        check({e.name, "_occ"},  {25'd0, buffer_occupancy}, {25'd0, e.occ});
        check({e.name, "_err"},  {31'd0, buffer_error},     {31'd0, e.err});
        check({e.name, "_head"}, {24'd0, rx_data},          {24'd0, e.head});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    n_rst = 1'b0;
    #12 n_rst = 1'b1;
    step();
    expect_state("reset", 7'd0, 1'b0, 8'h00);

    // Fall-through order
    store_tx_data = 1'b1; tx_data = 8'hA5;
    step();
    tx_data = 8'h3C;
    expect_state("push1", 7'd1, 1'b0, 8'hA5);
    step();
    store_tx_data = 1'b0;
    expect_state("push2", 7'd2, 1'b0, 8'hA5);
    get_tx_packet_data = 1'b1; byte_q.push_back(8'hA5);
    step();
    get_tx_packet_data = 1'b0;
    expect_state("pop1", 7'd1, 1'b0, 8'h3C);
    get_rx_data = 1'b1; byte_q.push_back(8'h3C);
    step();
    get_rx_data = 1'b0;
    expect_state("pop2", 7'd0, 1'b0, 8'h00);

    // Full, wrap-around (pointers start at 2) and overflow
    store_rx_packet_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rx_packet_data = 8'(i);
      step();
    end
    rx_packet_data = 8'hFF;
    expect_state("full", 7'd64, 1'b0, 8'h00);
    step();
    store_rx_packet_data = 1'b0;
    expect_state("overflow", 7'd64, 1'b1, 8'h00);
    get_rx_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      byte_q.push_back(8'(i));
      step();
    end
    get_rx_data = 1'b0;
    expect_state("drained", 7'd0, 1'b1, 8'h00);
    clear = 1'b1;
    step();
    clear = 1'b0;
    expect_state("clear1", 7'd0, 1'b0, 8'h00);

    // Simultaneous push and pop at 5, 64 and 0
    store_tx_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(8'h10 + i);
      step();
    end
    tx_data = 8'h15; get_rx_data = 1'b1; byte_q.push_back(8'h10);
    step();
    get_rx_data = 1'b0;
    expect_state("pushpop5", 7'd5, 1'b0, 8'h11);
    for (int i = 0; i < 59; i++) begin
      tx_data = 8'(8'h20 + i);
      step();
    end
    expect_state("refill", 7'd64, 1'b0, 8'h11);
    tx_data = 8'h77; get_rx_data = 1'b1; byte_q.push_back(8'h11);
    step();
    store_tx_data = 1'b0; get_rx_data = 1'b0;
    expect_state("pushpop64", 7'd64, 1'b0, 8'h12);
    clear = 1'b1;
    step();
    clear = 1'b0;
    store_tx_data = 1'b1; tx_data = 8'h55; get_rx_data = 1'b1;
    step();
    store_tx_data = 1'b0; get_rx_data = 1'b0;
    expect_state("pushpop0", 7'd1, 1'b1, 8'h55);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Underflow and collisions; pointers sit at 1 after one push/pop
    store_tx_data = 1'b1; tx_data = 8'h66;
    step();
    store_tx_data = 1'b0; get_rx_data = 1'b1; byte_q.push_back(8'h66);
    step();
    expect_state("underflow_pre", 7'd0, 1'b0, 8'h00);
    step();
    get_rx_data = 1'b0;
    expect_state("underflow", 7'd0, 1'b1, 8'h00);
    get_rx_data = 1'b1; get_tx_packet_data = 1'b1;
    step();
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    expect_state("pop_collision_empty", 7'd0, 1'b1, 8'h00);
    store_tx_data = 1'b1; tx_data = 8'h11;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h22;
    step();
    store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
    expect_state("push_collision", 7'd1, 1'b1, 8'h11);
    get_rx_data = 1'b1; get_tx_packet_data = 1'b1; byte_q.push_back(8'h11);
    step();
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    expect_state("pop_collision", 7'd0, 1'b1, 8'h00);

    // Clear with a concurrent push at occupancy 10, error set
    store_rx_packet_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_packet_data = 8'(8'h40 + i);
      step();
    end
    store_rx_packet_data = 1'b0;
    expect_state("pre_clear", 7'd10, 1'b1, 8'h40);
    clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'hEE;
    step();
    clear = 1'b0; store_tx_data = 1'b0;
    expect_state("clear_push", 7'd0, 1'b0, 8'h00);

    // Async reset between edges at occupancy 7
    store_tx_data = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tx_data = 8'(8'h70 + i);
      step();
    end
    store_tx_data = 1'b0;
    expect_state("pre_reset", 7'd7, 1'b0, 8'h70);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset_occ", {25'd0, buffer_occupancy}, 32'd0);
    check("async_reset_head", {24'd0, rx_data}, 32'd0);
    #1 n_rst = 1'b1;
    store_tx_data = 1'b1; tx_data = 8'h99;
    step();
    store_tx_data = 1'b0;
    expect_state("post_reset_push", 7'd1, 1'b0, 8'h99);

    @(negedge clk);
    #1;
    check("state_q_drained", state_q.size(), 32'd0);
    check("byte_q_drained", byte_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
